// File: rtl/time_keeper.sv
// 12-hour BCD real-time clock core: counts ms ticks into seconds, minutes,
// hours and AM/PM, with a set mode for manual hour/minute adjustment.
module time_keeper #(
  parameter int TICKS_PER_SEC = 1000,
  parameter int SEC_PER_MIN   = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_tick,
  input  logic        set_mode,
  input  logic        inc_hour,
  input  logic        inc_min,
  output logic [13:0] time_out,
  output logic        sec_pulse,
  output logic        setting
);

  localparam int MS_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int SEC_W = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
  localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(TICKS_PER_SEC - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);

  typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [MS_W-1:0]   ms_q, ms_d;
  logic [SEC_W-1:0]  sec_q, sec_d;
  logic [3:0]        min_ones_q, min_ones_d;
  logic [2:0]        min_tens_q, min_tens_d;
  logic [3:0]        hr_ones_q, hr_ones_d;
  logic [1:0]        hr_tens_q, hr_tens_d;
  logic              pm_q, pm_d;
  logic              pulse_q, pulse_d;
  logic              do_min, do_hour, carry_en, min_wrap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      ms_q       <= '0;
      sec_q      <= '0;
      min_ones_q <= 4'd0;
      min_tens_q <= 3'd0;
      hr_ones_q  <= 4'd2;
      hr_tens_q  <= 2'd1;
      pm_q       <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ms_q       <= ms_d;
      sec_q      <= sec_d;
      min_ones_q <= min_ones_d;
      min_tens_q <= min_tens_d;
      hr_ones_q  <= hr_ones_d;
      hr_tens_q  <= hr_tens_d;
      pm_q       <= pm_d;
      pulse_q    <= pulse_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ms_d       = ms_q;
    sec_d      = sec_q;
    min_ones_d = min_ones_q;
    min_tens_d = min_tens_q;
    hr_ones_d  = hr_ones_q;
    hr_tens_d  = hr_tens_q;
    pm_d       = pm_q;
    pulse_d    = 1'b0;
    do_min     = 1'b0;
    do_hour    = 1'b0;
    carry_en   = 1'b0;
    min_wrap   = (min_ones_q == 4'd9) && (min_tens_q == 3'd5);

    // A mode change edge only switches state and clears the counters;
    // neither ticks nor button pulses act on that edge.
    case (state_q)
      RUN: begin
        if (set_mode) begin
          state_d = SET;
          ms_d    = '0;
          sec_d   = '0;
        end else if (ms_tick) begin
          if (ms_q == MS_LAST) begin
            ms_d    = '0;
            pulse_d = 1'b1;
            if (sec_q == SEC_LAST) begin
              sec_d    = '0;
              do_min   = 1'b1;
              carry_en = 1'b1;
            end else begin
              sec_d = sec_q + 1'b1;
            end
          end else begin
            ms_d = ms_q + 1'b1;
          end
        end
      end
      SET: begin
        if (!set_mode) begin
          state_d = RUN;
          ms_d    = '0;
          sec_d   = '0;
        end else begin
          do_min  = inc_min;
          do_hour = inc_hour;
        end
      end
      default: state_d = RUN;
    endcase

    if (do_min) begin
      if (min_ones_q == 4'd9) begin
        min_ones_d = 4'd0;
        min_tens_d = (min_tens_q == 3'd5) ? 3'd0 : min_tens_q + 3'd1;
      end else begin
        min_ones_d = min_ones_q + 4'd1;
      end
    end

    // Hour sequence 12 -> 01 .. 09 -> 10 -> 11 -> 12; PM flips only entering 12.
    if (do_hour || (do_min && carry_en && min_wrap)) begin
      if (hr_tens_q == 2'd1 && hr_ones_q == 4'd2) begin
        hr_tens_d = 2'd0;
        hr_ones_d = 4'd1;
      end else if (hr_tens_q == 2'd0 && hr_ones_q == 4'd9) begin
        hr_tens_d = 2'd1;
        hr_ones_d = 4'd0;
      end else if (hr_tens_q == 2'd1 && hr_ones_q == 4'd1) begin
        hr_ones_d = 4'd2;
        pm_d      = ~pm_q;
      end else begin
        hr_ones_d = hr_ones_q + 4'd1;
      end
    end
  end

  assign time_out  = {pm_q, hr_tens_q, hr_ones_q, min_tens_q, min_ones_q};
  assign sec_pulse = pulse_q;
  assign setting   = (state_q == SET);

endmodule

// File: tb/tb_time_keeper.sv
// Bench for time_keeper: directed scenarios plus random stimulus, checked
// cycle by cycle against a minutes-of-day reference model.
module tb_time_keeper;

  localparam int TPS = 4;
  localparam int SPM = 3;
  localparam int TICKS_PER_MIN = TPS * SPM;

  logic        clk;
  logic        rst;
  logic        ms_tick;
  logic        set_mode;
  logic        inc_hour;
  logic        inc_min;
  logic [13:0] time_out;
  logic        sec_pulse;
  logic        setting;

  time_keeper #(.TICKS_PER_SEC(TPS), .SEC_PER_MIN(SPM)) dut (
    .clk      (clk),
    .rst      (rst),
    .ms_tick  (ms_tick),
    .set_mode (set_mode),
    .inc_hour (inc_hour),
    .inc_min  (inc_min),
    .time_out (time_out),
    .sec_pulse(sec_pulse),
    .setting  (setting)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [13:0] exp_q[$];

  // reference model: 24-hour clock hour, minute, plus tick/second counts
  int  m_h, m_m, m_ms, m_sec;
  bit  m_set, m_pulse;

  function automatic logic [13:0] enc(input int h, input int m);
    int h12;
    h12 = (h % 12 == 0) ? 12 : h % 12;
    return 14'(((h >= 12 ? 1 : 0) << 13) | ((h12 / 10) << 11) |
               ((h12 % 10) << 7) | ((m / 10) << 4) | (m % 10));
  endfunction

  function automatic void model_reset();
    m_h = 0; m_m = 0; m_ms = 0; m_sec = 0; m_set = 0; m_pulse = 0;
  endfunction

  function automatic void model_step(input bit tick, input bit sm,
                                     input bit ih, input bit im);
    m_pulse = 0;
    if (m_set != sm) begin
      m_set = sm; m_ms = 0; m_sec = 0;
    end else if (!m_set) begin
      if (tick) begin
        m_ms++;
        if (m_ms == TPS) begin
          m_ms = 0; m_pulse = 1; m_sec++;
          if (m_sec == SPM) begin
            m_sec = 0; m_m++;
            if (m_m == 60) begin m_m = 0; m_h = (m_h + 1) % 24; end
          end
        end
      end
    end else begin
      if (im) m_m = (m_m + 1) % 60;
      if (ih) m_h = (m_h + 1) % 24;
    end
  endfunction

  task automatic check(input string tag, input logic [13:0] got,
                       input logic [13:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: one clock cycle with the given inputs, then scoreboard check
  task automatic step(input bit tick, input bit sm, input bit ih, input bit im);
    ms_tick = tick; set_mode = sm; inc_hour = ih; inc_min = im;
    @(posedge clk);
    model_step(tick, sm, ih, im);
    exp_q.push_back(enc(m_h, m_m));
    #1;
    check("time_out", time_out, exp_q.pop_front());
    check("sec_pulse", {13'd0, sec_pulse}, {13'd0, m_pulse});
    check("setting", {13'd0, setting}, {13'd0, m_set});
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("rst_time", time_out, 14'h0900);
    check("rst_setting", {13'd0, setting}, 14'd0);
    check("rst_pulse", {13'd0, sec_pulse}, 14'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
  endtask

  task automatic set_time(input int th, input int tm);
    step(0, 1, 0, 0);
    while (m_h != th) step(0, 1, 1, 0);
    while (m_m != tm) step(0, 1, 0, 1);
    step(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b0; ms_tick = 0; set_mode = 0; inc_hour = 0; inc_min = 0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // seconds and first minute from reset
    run_ticks(TICKS_PER_MIN);
    check("min_after_12", time_out, 14'h0901);

    // 11:59 AM -> 12:00 PM, then 12:59 PM -> 01:00 PM
    set_time(11, 59);
    run_ticks(TICKS_PER_MIN);
    check("roll_12pm", time_out, 14'h2900);
    set_time(12, 59);
    run_ticks(TICKS_PER_MIN);
    check("roll_1pm", time_out, 14'h2080);

    // SET adjust from 12:00 AM with ticks present and ignored
    do_reset();
    step(0, 1, 0, 0);
    for (int i = 0; i < 61; i++) begin
      step(1, 1, 0, 1);
      step(1, 1, 0, 0);
    end
    check("set_61min", time_out, 14'h0901);
    for (int i = 0; i < 12; i++) step(1, 1, 1, 0);
    check("set_12hr", time_out, 14'h2901);
    step(0, 0, 0, 0);

    // simultaneous inc_hour + inc_min at 09:59 AM in SET, then in RUN
    set_time(9, 59);
    step(0, 1, 0, 0);
    step(0, 1, 1, 1);
    check("simul_set", time_out, 14'h0800);
    step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    check("simul_run", time_out, 14'h0800);

    // set_mode rises with the minute-completing tick
    run_ticks(TICKS_PER_MIN - 1);
    step(1, 1, 0, 0);
    check("race_time", time_out, 14'h0800);
    check("race_setting", {13'd0, setting}, 14'd1);
    step(0, 0, 0, 0);
    run_ticks(TICKS_PER_MIN - 1);
    check("race_hold", time_out, 14'h0800);
    run_ticks(1);
    check("race_full_min", time_out, 14'h0801);

    // reset asserted mid-SET
    step(0, 1, 0, 0);
    step(0, 1, 1, 1);
    do_reset();

    // random stimulus
    begin
      bit sm = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 39) == 0) sm = ~sm;
        step(1'($urandom_range(0, 1)), sm, 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 3) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
